// File: rtl/reg_ctl_pkg.sv
// Shared constants and state encoding for the byte-stream register access controller.
package reg_ctl_pkg;

  localparam int WR_BYTES = 8;
  localparam int RD_BYTES = 16;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_RD = 8'h3B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

endpackage

// File: rtl/reg_ctl.sv
// Command parser between the SPI byte stream and the register file: 8-byte config
// writes into a 64-bit word, and 16-byte snapshot reads streamed out over valid/ready.
module reg_ctl
  import reg_ctl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_i,
  input  logic        rx_vld_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_vld_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_rdy_i,
  output logic        reg_wr_en_o,
  output logic [63:0] reg_wr_data_o,
  output logic        reg_rd_en_o,
  output logic [3:0]  reg_rd_addr_o,
  input  logic [7:0]  reg_rd_data_i,
  output state_t      dbg_state
);

  // Handshake: a tx byte transfers on any clock edge where tx_vld_o and tx_rdy_i
  // are both high; while tx_vld_o is high and tx_rdy_i low, tx_data_o is held.

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]  addr_q, addr_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        wr_en_q, wr_en_d;
  logic        tx_vld_q, tx_vld_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rd_en_q, rd_en_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    tx_vld_d  = tx_vld_q;
    tx_data_d = tx_data_q;
    rd_en_d   = rd_en_q;
    // A dropped frame wins over everything, including a byte strobed the same cycle.
    if (!frame_i) begin
      state_d  = ST_IDLE;
      cnt_d    = 3'd0;
      rd_cnt_d = 5'd0;
      addr_d   = 4'd0;
      tx_vld_d = 1'b0;
      rd_en_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_vld_i) begin
            if (rx_data_i == CMD_CONF_WR) begin
              state_d = ST_WR_DATA;
              cnt_d   = 3'd0;
            end else if (rx_data_i == CMD_DATA_RD) begin
              state_d  = ST_RD_DATA;
              rd_en_d  = 1'b1;
              addr_d   = 4'd0;
              rd_cnt_d = 5'd0;
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
        ST_WR_DATA: begin
          if (rx_vld_i) begin
            shadow_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(WR_BYTES - 1)) begin
              wr_data_d = shadow_d;
              wr_en_d   = 1'b1;
              state_d   = ST_DISCARD;
            end
          end
        end
        ST_RD_DATA: begin
          // Refill the single output slot when empty or draining, until all bytes are loaded.
          if ((!tx_vld_q || tx_rdy_i) && (rd_cnt_q != 5'(RD_BYTES))) begin
            tx_data_d = reg_rd_data_i;
            tx_vld_d  = 1'b1;
            addr_d    = addr_q + 4'd1;
            rd_cnt_d  = rd_cnt_q + 5'd1;
          end else if (tx_vld_q && tx_rdy_i) begin
            tx_vld_d = 1'b0;
            state_d  = ST_DISCARD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= 3'd0;
      rd_cnt_q  <= 5'd0;
      addr_q    <= 4'd0;
      shadow_q  <= 64'd0;
      wr_data_q <= 64'd0;
      wr_en_q   <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= 8'd0;
      rd_en_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      rd_en_q   <= rd_en_d;
    end
  end

  assign tx_vld_o      = tx_vld_q;
  assign tx_data_o     = tx_data_q;
  assign reg_wr_en_o   = wr_en_q;
  assign reg_wr_data_o = wr_data_q;
  assign reg_rd_en_o   = rd_en_q;
  assign reg_rd_addr_o = addr_q;
  assign dbg_state     = state_q;

endmodule
